// File: rtl/keypad_pkg.sv
// Shared key codes, debounce FSM state encoding and the matrix-position-to-key lookup
// for the keypad decimal entry block.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        IDLE_SCAN,
        PRESS_DEB,
        HELD,
        REL_DEB
    } state_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h3:    code = KEY_A;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h7:    code = KEY_B;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = KEY_0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: prescaler, one-hot-low column drive, 2-flop row synchronizer and
// per-scan first-key-wins result, reported as a one-clk pulse after column 3 is sampled.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic       o_scan_done,
    output logic       o_scan_hit,
    output logic [3:0] o_scan_code
);

    logic [SCAN_DIV_BITS-1:0] r_presc;
    logic [3:0]               r_sync1;
    logic [3:0]               r_sync2;
    logic [1:0]               r_col;
    logic [3:0]               r_col_drv;
    logic                     r_found;
    logic [3:0]               r_code;
    logic                     r_done;
    logic                     r_hit;
    logic [3:0]               r_res_code;

    logic       w_tick;
    logic [1:0] w_col_next;
    logic       w_row_hit;
    logic [1:0] w_row_idx;
    logic [3:0] w_code_now;

    assign w_tick     = (r_presc == '1);
    assign w_col_next = r_col + 2'd1;
    assign w_code_now = key_lookup(w_row_idx, r_col);

    // Lowest-numbered active row in the currently driven column wins.
    always_comb begin
        w_row_hit = 1'b0;
        w_row_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r_sync2[i] && !w_row_hit) begin
                w_row_hit = 1'b1;
                w_row_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc    <= '0;
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_col      <= '0;
            r_col_drv  <= 4'b1110;
            r_found    <= 1'b0;
            r_code     <= '0;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_res_code <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_sync1 <= i_row;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            if (w_tick) begin
                r_col     <= w_col_next;
                r_col_drv <= ~(4'b0001 << w_col_next);
                if (r_col == 2'd0) begin
                    r_found <= w_row_hit;
                    r_code  <= w_code_now;
                end else if (!r_found && w_row_hit) begin
                    r_found <= 1'b1;
                    r_code  <= w_code_now;
                end
                if (r_col == 2'd3) begin
                    r_done     <= 1'b1;
                    r_hit      <= r_found || w_row_hit;
                    r_res_code <= r_found ? r_code : w_code_now;
                end
            end
        end
    end

    assign o_col       = r_col_drv;
    assign o_scan_done = r_done;
    assign o_scan_hit  = r_hit;
    assign o_scan_code = r_res_code;

endmodule

// File: rtl/keypad_dec_entry.sv
// Keypad decimal entry: debounce FSM and two-operand accumulator on top of keypad_scanner.
// Define KEYPAD_SAT_EN to saturate overflowing digit entry at 255 instead of discarding it.
module keypad_dec_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS = 16,
    parameter int DEB_SCANS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] numA,
    output logic [7:0] numB,
    output logic       sel_b,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic       commit
);

    logic       w_scan_done;
    logic       w_scan_hit;
    logic [3:0] w_scan_code;

    keypad_scanner #(.SCAN_DIV_BITS(SCAN_DIV_BITS)) u_scanner (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_row       (row_in),
        .o_col       (col_out),
        .o_scan_done (w_scan_done),
        .o_scan_hit  (w_scan_hit),
        .o_scan_code (w_scan_code)
    );

    state_t     r_state;
    logic [3:0] r_cand;
    logic [3:0] r_cnt;
    logic [7:0] r_numA;
    logic [7:0] r_numB;
    logic       r_sel_b;
    logic [3:0] r_key_code;
    logic       r_strobe;
    logic       r_commit;

    logic [7:0]  w_cur;
    logic [11:0] w_prod;
    logic [7:0]  w_op;
    logic [4:0]  w_cnt_next;
    logic        w_deb_done;

    assign w_cur      = r_sel_b ? r_numB : r_numA;
    assign w_prod     = 12'(w_cur) * 12'd10 + 12'(r_cand);
    assign w_cnt_next = {1'b0, r_cnt} + 5'd1;
    assign w_deb_done = (w_cnt_next >= 5'(DEB_SCANS));

    // New value of the active operand if r_cand were accepted now.
    always_comb begin
        w_op = w_cur;
        if (r_cand <= KEY_9) begin
            if (w_prod > 12'd255) begin
`ifdef KEYPAD_SAT_EN
                w_op = 8'd255;
`else
                w_op = w_cur;
`endif
            end else begin
                w_op = w_prod[7:0];
            end
        end else if (r_cand == KEY_C) begin
            w_op = '0;
        end else if (r_cand == KEY_STAR) begin
            w_op = w_cur / 8'd10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE_SCAN;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_numA     <= '0;
            r_numB     <= '0;
            r_sel_b    <= 1'b0;
            r_key_code <= '0;
            r_strobe   <= 1'b0;
            r_commit   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_commit <= 1'b0;
            if (w_scan_done) begin
                case (r_state)
                    IDLE_SCAN: begin
                        if (w_scan_hit) begin
                            r_state <= PRESS_DEB;
                            r_cand  <= w_scan_code;
                            r_cnt   <= 4'd1;
                        end
                    end
                    PRESS_DEB: begin
                        if (w_scan_hit && (w_scan_code == r_cand)) begin
                            if (w_deb_done) begin
                                r_state    <= HELD;
                                r_key_code <= r_cand;
                                r_strobe   <= 1'b1;
                                r_commit   <= (r_cand == KEY_D);
                                if (r_cand == KEY_A)
                                    r_sel_b <= 1'b0;
                                else if (r_cand == KEY_B)
                                    r_sel_b <= 1'b1;
                                if (r_sel_b)
                                    r_numB <= w_op;
                                else
                                    r_numA <= w_op;
                            end else begin
                                r_cnt <= w_cnt_next[3:0];
                            end
                        end else begin
                            r_state <= IDLE_SCAN;
                        end
                    end
                    HELD: begin
                        if (!w_scan_hit) begin
                            r_state <= REL_DEB;
                            r_cnt   <= 4'd1;
                        end
                    end
                    REL_DEB: begin
                        if (w_scan_hit)
                            r_state <= HELD;
                        else if (w_deb_done)
                            r_state <= IDLE_SCAN;
                        else
                            r_cnt <= w_cnt_next[3:0];
                    end
                    default: r_state <= IDLE_SCAN;
                endcase
            end
        end
    end

    assign numA       = r_numA;
    assign numB       = r_numB;
    assign sel_b      = r_sel_b;
    assign key_code   = r_key_code;
    assign key_strobe = r_strobe;
    assign commit     = r_commit;

endmodule

// File: tb/tb_keypad_dec_entry.sv
// Directed bench for keypad_dec_entry with a behavioural 4x4 keypad matrix on the column/row lines.
`timescale 1ns/1ps
module tb_keypad_dec_entry;

    localparam int SCAN_CLKS = 16;  // 4 columns x 2**2 clk per column

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [7:0] numA;
    logic [7:0] numB;
    logic       sel_b;
    logic [3:0] key_code;
    logic       key_strobe;
    logic       commit;

    logic [15:0] pressed = '0;
    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    int commits = 0;

    keypad_dec_entry #(.SCAN_DIV_BITS(2), .DEB_SCANS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .numA       (numA),
        .numB       (numB),
        .sel_b      (sel_b),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .commit     (commit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_strobe) strobes++;
        if (commit) commits++;
    end

    // Pressed switch at (r,c) shorts row r to column c while that column is driven low.
    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    function automatic int key_idx(input logic [3:0] code);
        case (code)
            4'd1: return 0;   4'd2: return 1;   4'd3: return 2;   4'd10: return 3;
            4'd4: return 4;   4'd5: return 5;   4'd6: return 6;   4'd11: return 7;
            4'd7: return 8;   4'd8: return 9;   4'd9: return 10;  4'd12: return 11;
            4'd14: return 12; 4'd0: return 13;  4'd15: return 14; default: return 15;
        endcase
    endfunction

    task automatic hold_key(input logic [3:0] code, input int nscans);
        pressed[key_idx(code)] = 1'b1;
        repeat (nscans * SCAN_CLKS) @(negedge clk);
    endtask

    task automatic release_keys(input int nscans);
        pressed = '0;
        repeat (nscans * SCAN_CLKS) @(negedge clk);
    endtask

    task automatic tap(input logic [3:0] code);
        hold_key(code, 4);
        release_keys(4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({col_out, numA, numB, sel_b, key_code, key_strobe, commit} !== {4'b1110, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: col=%b A=%0d B=%0d sel=%b code=%0d stb=%b cmt=%b expected col=1110 rest 0",
                     col_out, numA, numB, sel_b, key_code, key_strobe, commit);
        end
        rst = 1'b0;
        repeat (2 * SCAN_CLKS) @(negedge clk);
    endtask

    task automatic test_digits_a;
        int s0;
        s0 = strobes;
        tap(4'd1);
        tap(4'd2);
        tap(4'd3);
        checks++;
        if (numA !== 8'd123) begin errors++; $display("FAIL digits_numA: got %0d expected 123", numA); end
        checks++;
        if (strobes - s0 !== 3) begin errors++; $display("FAIL digits_strobes: got %0d expected 3", strobes - s0); end
        checks++;
        if (sel_b !== 1'b0) begin errors++; $display("FAIL digits_sel_b: got %b expected 0", sel_b); end
        checks++;
        if (key_code !== 4'd3) begin errors++; $display("FAIL digits_key_code: got %0d expected 3", key_code); end
    endtask

    task automatic test_overflow_b;
        logic [7:0] exp_b;
`ifdef KEYPAD_SAT_EN
        exp_b = 8'd255;
`else
        exp_b = 8'd25;
`endif
        tap(4'd11);
        checks++;
        if (sel_b !== 1'b1) begin errors++; $display("FAIL ovf_sel_b: got %b expected 1", sel_b); end
        tap(4'd2);
        tap(4'd5);
        checks++;
        if (numB !== 8'd25) begin errors++; $display("FAIL ovf_numB_25: got %0d expected 25", numB); end
        tap(4'd6);
        checks++;
        if (numB !== exp_b) begin errors++; $display("FAIL ovf_numB: got %0d expected %0d", numB, exp_b); end
        checks++;
        if (numA !== 8'd123) begin errors++; $display("FAIL ovf_numA: got %0d expected 123", numA); end
        checks++;
        if (key_code !== 4'd6) begin errors++; $display("FAIL ovf_key_code: got %0d expected 6", key_code); end
    endtask

    task automatic test_edit;
        int c0;
        tap(4'd10);
        checks++;
        if (sel_b !== 1'b0) begin errors++; $display("FAIL edit_sel_a: got %b expected 0", sel_b); end
        tap(4'd14);
        checks++;
        if (numA !== 8'd12) begin errors++; $display("FAIL edit_backspace: got %0d expected 12", numA); end
        tap(4'd12);
        checks++;
        if (numA !== 8'd0) begin errors++; $display("FAIL edit_clear: got %0d expected 0", numA); end
        c0 = commits;
        tap(4'd13);
        checks++;
        if (commits - c0 !== 1) begin errors++; $display("FAIL edit_commit_count: got %0d expected 1", commits - c0); end
        checks++;
        if (numA !== 8'd0 || key_code !== 4'd13) begin
            errors++; $display("FAIL edit_after_commit: numA=%0d code=%0d expected 0 and 13", numA, key_code);
        end
    endtask

    task automatic test_glitch;
        int s0;
        s0 = strobes;
        pressed[key_idx(4'd7)] = 1'b1;
        repeat (SCAN_CLKS / 2) @(negedge clk);
        release_keys(4);
        checks++;
        if (strobes - s0 !== 0) begin errors++; $display("FAIL glitch_strobe: got %0d expected 0", strobes - s0); end
        checks++;
        if (numA !== 8'd0) begin errors++; $display("FAIL glitch_numA: got %0d expected 0", numA); end
        tap(4'd7);
        checks++;
        if (numA !== 8'd7) begin errors++; $display("FAIL steady7_numA: got %0d expected 7", numA); end
    endtask

    task automatic test_rollover;
        int s0;
        s0 = strobes;
        pressed[key_idx(4'd4)] = 1'b1;
        pressed[key_idx(4'd9)] = 1'b1;
        repeat (4 * SCAN_CLKS) @(negedge clk);
        checks++;
        if (key_code !== 4'd4 || numA !== 8'd74) begin
            errors++; $display("FAIL rollover_first: code=%0d numA=%0d expected 4 and 74", key_code, numA);
        end
        pressed[key_idx(4'd4)] = 1'b0;
        repeat (4 * SCAN_CLKS) @(negedge clk);
        release_keys(4);
        checks++;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL rollover_strobes: got %0d expected 1", strobes - s0); end
        checks++;
        if (numA !== 8'd74) begin errors++; $display("FAIL rollover_numA: got %0d expected 74", numA); end
    endtask

    task automatic test_reset_press_deb;
        int s0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pressed[key_idx(4'd5)] = 1'b1;
        rst = 1'b0;
        s0 = strobes;
        // first hit reported ~17 clk after release, acceptance ~33: 25 clk lands mid-debounce
        repeat (25) @(negedge clk);
        checks++;
        if (strobes - s0 !== 0) begin errors++; $display("FAIL rst_deb_early_strobe: got %0d expected 0", strobes - s0); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({col_out, numA, numB, sel_b, key_code, key_strobe, commit} !== {4'b1110, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_deb_values: col=%b A=%0d B=%0d sel=%b code=%0d stb=%b cmt=%b expected col=1110 rest 0",
                     col_out, numA, numB, sel_b, key_code, key_strobe, commit);
        end
        @(negedge clk);
        rst = 1'b0;
        s0 = strobes;
        repeat (5 * SCAN_CLKS) @(negedge clk);
        checks++;
        if (strobes - s0 !== 1 || numA !== 8'd5) begin
            errors++; $display("FAIL rst_deb_reaccept: strobes=%0d numA=%0d expected 1 and 5", strobes - s0, numA);
        end
        release_keys(4);
    endtask

    task automatic test_reset_held;
        int s0;
        int budget;
        s0 = strobes;
        pressed[key_idx(4'd8)] = 1'b1;
        budget = 0;
        while (strobes == s0 && budget < 10 * SCAN_CLKS) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (strobes == s0) begin errors++; $display("FAIL held_wait_strobe: got 0 strobes expected 1 within %0d clk", budget); end
        checks++;
        if (numA !== 8'd58) begin errors++; $display("FAIL held_numA: got %0d expected 58", numA); end
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({col_out, numA, numB, sel_b, key_code, key_strobe, commit} !== {4'b1110, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_held_values: col=%b A=%0d B=%0d sel=%b code=%0d stb=%b cmt=%b expected col=1110 rest 0",
                     col_out, numA, numB, sel_b, key_code, key_strobe, commit);
        end
        @(negedge clk);
        rst = 1'b0;
        s0 = strobes;
        repeat (5 * SCAN_CLKS) @(negedge clk);
        checks++;
        if (strobes - s0 !== 1 || numA !== 8'd8 || key_code !== 4'd8) begin
            errors++; $display("FAIL rst_held_reaccept: strobes=%0d numA=%0d code=%0d expected 1, 8, 8",
                               strobes - s0, numA, key_code);
        end
        release_keys(4);
    endtask

    initial begin
        test_reset();
        test_digits_a();
        test_overflow_b();
        test_edit();
        test_glitch();
        test_rollover();
        test_reset_press_deb();
        test_reset_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
